// File: rtl/mdll_fcal_ctrl_pkg.sv
// Shared widths, defaults and state encoding for the MDLL frequency-calibration controller.
package mdll_fcal_ctrl_pkg;

   localparam int N_DCO_O       = 5;
   localparam int N_FCAL_CNT    = 12;
   localparam int FCAL_N_SETTLE = 4;
   localparam int FCAL_N_TMO    = 16;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_SET,
      ST_LOAD,
      ST_SETTLE,
      ST_REQ,
      ST_WAIT_ACK,
      ST_WAIT_REL,
      ST_DECIDE,
      ST_FLOAD,
      ST_DONE,
      ST_ERR
   } fcal_ctrl_st_t;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/mdll_fcal_ctrl_sync.sv
// Two-flop synchronizer for the fcal_ready acknowledge coming from the core.
module mdll_fcal_ctrl_sync (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/mdll_fcal_ctrl.sv
// MDLL fcal initiator: SAR search over dco_ctl_offset using a four-phase req/ack with the core.
//
// state       | meaning
// ST_IDLE     | waiting for cal_go
// ST_SET      | set trial bit offset[idx]
// ST_LOAD     | load_offset strobe for the trial value
// ST_SETTLE   | wait 2**N_SETTLE cycles for the DCO to settle
// ST_REQ      | en_fcal on; hold off start until a stale ack clears
// ST_WAIT_ACK | fcal_start high, wait for synchronized ready, capture count
// ST_WAIT_REL | start low, wait for ready to fall
// ST_DECIDE   | keep or clear trial bit, next bit or final load
// ST_FLOAD    | load_offset strobe for the final value
// ST_DONE     | result valid (sticky done)
// ST_ERR      | handshake timeout (sticky err), offset reloaded as 0
module mdll_fcal_ctrl
   import mdll_fcal_ctrl_pkg::*;
#(
   parameter int N_SETTLE = FCAL_N_SETTLE,
   parameter int N_TMO    = FCAL_N_TMO
) (
   input  logic                  clk_refp_i,
   input  logic                  rstn_i,
   input  logic                  cal_en_i,
   input  logic                  cal_go_i,
   input  logic [N_FCAL_CNT-1:0] cal_target_i,
   input  logic [N_FCAL_CNT-1:0] fcal_cnt_i,
   input  logic                  fcal_ready_i,
   output logic                  en_fcal_o,
   output logic                  fcal_start_o,
   output logic                  load_offset_o,
   output logic [N_DCO_O-1:0]    dco_ctl_offset_o,
   output logic                  cal_busy_o,
   output logic                  cal_done_o,
   output logic                  cal_err_o
);

   localparam int CW = max_int(N_SETTLE, N_TMO);
   localparam int IW = (N_DCO_O > 1) ? $clog2(N_DCO_O) : 1;
   localparam logic [CW-1:0] SETTLE_LD = CW'((1 << N_SETTLE) - 1);
   localparam logic [CW-1:0] TMO_LD    = CW'((1 << N_TMO) - 1);
   localparam logic [IW-1:0] IDX_MSB   = IW'(N_DCO_O - 1);

   fcal_ctrl_st_t         st_q, st_d;
   logic [N_DCO_O-1:0]    off_q, off_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic [CW-1:0]         tmr_q, tmr_d;
   logic [N_FCAL_CNT-1:0] tgt_q, tgt_d;
   logic [N_FCAL_CNT-1:0] cnt_q, cnt_d;
   logic                  load_q, load_d;
   logic                  start_q, start_d;
   logic                  en_q, en_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;
   logic                  rdy_s;
   logic                  tmo_hit;

   mdll_fcal_ctrl_sync u_rdy_sync (
      .clk_i   (clk_refp_i),
      .rst_n_i (rstn_i),
      .d_i     (fcal_ready_i),
      .q_o     (rdy_s)
   );

   always_ff @(posedge clk_refp_i or negedge rstn_i) begin
      if (!rstn_i) begin
         st_q    <= ST_IDLE;
         off_q   <= '0;
         idx_q   <= '0;
         tmr_q   <= '0;
         tgt_q   <= '0;
         cnt_q   <= '0;
         load_q  <= 1'b0;
         start_q <= 1'b0;
         en_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         st_q    <= st_d;
         off_q   <= off_d;
         idx_q   <= idx_d;
         tmr_q   <= tmr_d;
         tgt_q   <= tgt_d;
         cnt_q   <= cnt_d;
         load_q  <= load_d;
         start_q <= start_d;
         en_q    <= en_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      st_d    = st_q;
      off_d   = off_q;
      idx_d   = idx_q;
      tmr_d   = tmr_q;
      tgt_d   = tgt_q;
      cnt_d   = cnt_q;
      load_d  = 1'b0;
      start_d = start_q;
      en_d    = en_q;
      busy_d  = busy_q;
      done_d  = done_q;
      err_d   = err_q;
      tmo_hit = 1'b0;

      if (!cal_en_i) begin
         // Abort leaves the offset where it is; the core keeps its last loaded value.
         st_d    = ST_IDLE;
         start_d = 1'b0;
         en_d    = 1'b0;
         busy_d  = 1'b0;
         done_d  = 1'b0;
         err_d   = 1'b0;
      end else begin
         case (st_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
               if (cal_go_i) begin
                  tgt_d  = cal_target_i;
                  idx_d  = IDX_MSB;
                  off_d  = '0;
                  busy_d = 1'b1;
                  done_d = 1'b0;
                  err_d  = 1'b0;
                  st_d   = ST_SET;
               end
            end
            ST_SET: begin
               off_d[idx_q] = 1'b1;
               load_d       = 1'b1;
               st_d         = ST_LOAD;
            end
            ST_LOAD: begin
               tmr_d = SETTLE_LD;
               st_d  = ST_SETTLE;
            end
            ST_SETTLE: begin
               if (tmr_q == '0) begin
                  en_d  = 1'b1;
                  tmr_d = TMO_LD;
                  st_d  = ST_REQ;
               end else begin
                  tmr_d = tmr_q - CW'(1);
               end
            end
            ST_REQ: begin
               // A stale ack must clear before a new request, or the four-phase cycle breaks.
               if (!rdy_s) begin
                  start_d = 1'b1;
                  tmr_d   = TMO_LD;
                  st_d    = ST_WAIT_ACK;
               end else if (tmr_q == '0) begin
                  tmo_hit = 1'b1;
               end else begin
                  tmr_d = tmr_q - CW'(1);
               end
            end
            ST_WAIT_ACK: begin
               if (rdy_s) begin
                  cnt_d   = fcal_cnt_i;
                  start_d = 1'b0;
                  tmr_d   = TMO_LD;
                  st_d    = ST_WAIT_REL;
               end else if (tmr_q == '0) begin
                  tmo_hit = 1'b1;
               end else begin
                  tmr_d = tmr_q - CW'(1);
               end
            end
            ST_WAIT_REL: begin
               if (!rdy_s) begin
                  st_d = ST_DECIDE;
               end else if (tmr_q == '0) begin
                  tmo_hit = 1'b1;
               end else begin
                  tmr_d = tmr_q - CW'(1);
               end
            end
            ST_DECIDE: begin
               // Count too low means the DCO runs too slow: back off this delay bit.
               if (cnt_q < tgt_q) begin
                  off_d[idx_q] = 1'b0;
               end
               if (idx_q == '0) begin
                  load_d = 1'b1;
                  st_d   = ST_FLOAD;
               end else begin
                  idx_d = idx_q - IW'(1);
                  st_d  = ST_SET;
               end
            end
            ST_FLOAD: begin
               busy_d = 1'b0;
               done_d = 1'b1;
               en_d   = 1'b0;
               st_d   = ST_DONE;
            end
            default: begin
               st_d = ST_IDLE;
            end
         endcase

         if (tmo_hit) begin
            start_d = 1'b0;
            en_d    = 1'b0;
            busy_d  = 1'b0;
            err_d   = 1'b1;
            off_d   = '0;
            load_d  = 1'b1;
            st_d    = ST_ERR;
         end
      end
   end

   assign en_fcal_o        = en_q;
   assign fcal_start_o     = start_q;
   assign load_offset_o    = load_q;
   assign dco_ctl_offset_o = off_q;
   assign cal_busy_o       = busy_q;
   assign cal_done_o       = done_q;
   assign cal_err_o        = err_q;

endmodule

// File: tb/tb_mdll_fcal_ctrl.sv
// Bench for mdll_fcal_ctrl: core model with cnt = 1000 - 20*offset, ack 8 cycles after start.
module tb_mdll_fcal_ctrl;
   import mdll_fcal_ctrl_pkg::*;

   localparam int TB_N_TMO = 8;
   localparam int TMO_CYC  = 1 << TB_N_TMO;

   logic                  clk = 1'b0;
   logic                  rstn;
   logic                  cal_en;
   logic                  cal_go;
   logic [N_FCAL_CNT-1:0] cal_target;
   logic [N_FCAL_CNT-1:0] fcal_cnt;
   logic                  fcal_ready;
   logic                  en_fcal;
   logic                  fcal_start;
   logic                  load_offset;
   logic [N_DCO_O-1:0]    dco_ctl_offset;
   logic                  cal_busy;
   logic                  cal_done;
   logic                  cal_err;

   int n_vec = 0;
   int n_mis = 0;

   logic never_rdy = 1'b0;
   logic force_rdy = 1'b0;
   logic rdy_norm  = 1'b0;
   int   k_core    = 0;
   logic [N_DCO_O-1:0] loads[$];

   always #5 clk = ~clk;

   mdll_fcal_ctrl #(.N_SETTLE(4), .N_TMO(TB_N_TMO)) dut (
      .clk_refp_i       (clk),
      .rstn_i           (rstn),
      .cal_en_i         (cal_en),
      .cal_go_i         (cal_go),
      .cal_target_i     (cal_target),
      .fcal_cnt_i       (fcal_cnt),
      .fcal_ready_i     (fcal_ready),
      .en_fcal_o        (en_fcal),
      .fcal_start_o     (fcal_start),
      .load_offset_o    (load_offset),
      .dco_ctl_offset_o (dco_ctl_offset),
      .cal_busy_o       (cal_busy),
      .cal_done_o       (cal_done),
      .cal_err_o        (cal_err)
   );

   // Core model: ack 8 cycles after start, held until start drops.
   always @(negedge clk) begin
      if (!rstn || !fcal_start) begin
         k_core   = 0;
         rdy_norm = 1'b0;
      end else begin
         if (k_core < 8) k_core = k_core + 1;
         if (k_core >= 8 && !never_rdy) rdy_norm = 1'b1;
      end
      if (rstn && load_offset) loads.push_back(dco_ctl_offset);
   end

   assign fcal_ready = force_rdy | rdy_norm;
   assign fcal_cnt   = N_FCAL_CNT'(1000 - 20 * int'(dco_ctl_offset));

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_mis++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Reference: largest offset whose count 1000-20*o still meets the target.
   function automatic int ref_offset(input int t);
      int o;
      if (t > 1000) return 0;
      o = (1000 - t) / 20;
      return (o > 31) ? 31 : o;
   endfunction

   task automatic run_cal(input int t, input bit poke, output bit fin);
      fin = 1'b0;
      loads.delete();
      cal_target = N_FCAL_CNT'(t);
      cal_go = 1'b1;
      tick();
      cal_go = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         cal_go = poke && (i == 30);
         if (poke) cal_target = N_FCAL_CNT'($urandom_range(0, 4095));
         tick();
         if (cal_done || cal_err) begin
            fin = 1'b1;
            break;
         end
      end
      cal_go = 1'b0;
   endtask

   typedef struct {
      int target;
      int exp_off;
      int exp_loads;
   } vec_t;

   initial begin
      vec_t tbl[6];
      int   seq700[6];
      bit   fin;
      int   t, c, okflag;

      tbl[0] = '{700, 15, 6};
      tbl[1] = '{1001, 0, 6};
      tbl[2] = '{0, 31, 6};
      tbl[3] = '{380, 31, 6};
      tbl[4] = '{381, 30, 6};
      tbl[5] = '{500, 25, 6};
      seq700 = '{16, 8, 12, 14, 15, 15};

      rstn = 1'b0; cal_en = 1'b0; cal_go = 1'b0; cal_target = '0;
      tick(); tick(); tick();
      chk("reset_outputs", int'({en_fcal, fcal_start, load_offset, dco_ctl_offset,
                                 cal_busy, cal_done, cal_err}), 0);
      rstn = 1'b1;
      tick();
      cal_en = 1'b1;
      tick();

      for (int i = 0; i < 6; i++) begin
         run_cal(tbl[i].target, 1'b0, fin);
         chk($sformatf("tbl%0d_finish", i), int'(fin), 1);
         chk($sformatf("tbl%0d_done", i), int'({cal_done, cal_err, cal_busy, en_fcal}), 8);
         chk($sformatf("tbl%0d_offset", i), int'(dco_ctl_offset), tbl[i].exp_off);
         chk($sformatf("tbl%0d_loads", i), loads.size(), tbl[i].exp_loads);
      end

      run_cal(700, 1'b0, fin);
      for (int i = 0; i < 6; i++)
         chk($sformatf("seq700_load%0d", i), (i < loads.size()) ? int'(loads[i]) : -1, seq700[i]);

      for (int r = 0; r < 8; r++) begin
         t = $urandom_range(0, 1100);
         run_cal(t, r[0], fin);
         chk($sformatf("rnd%0d_t%0d_finish", r, t), int'(fin & cal_done), 1);
         chk($sformatf("rnd%0d_t%0d_offset", r, t), int'(dco_ctl_offset), ref_offset(t));
         chk($sformatf("rnd%0d_t%0d_loads", r, t), loads.size(), 6);
      end

      // Ack never arrives: timeout from the rising edge of fcal_start.
      never_rdy = 1'b1;
      loads.delete();
      cal_target = N_FCAL_CNT'(700);
      cal_go = 1'b1;
      tick();
      cal_go = 1'b0;
      fin = 1'b0;
      for (int i = 0; i < 500; i++) begin
         if (fcal_start) begin fin = 1'b1; break; end
         tick();
      end
      chk("tmo_start_seen", int'(fin), 1);
      c = 0;
      for (int i = 0; i < 2 * TMO_CYC; i++) begin
         if (cal_err) break;
         tick();
         c++;
      end
      chk("tmo_cycles_in_window", int'(c >= TMO_CYC - 2 && c <= TMO_CYC + 2), 1);
      chk("tmo_flags", int'({cal_err, cal_done, cal_busy, en_fcal, fcal_start}), 16);
      chk("tmo_offset", int'(dco_ctl_offset), 0);
      tick(); tick();
      chk("tmo_loads", loads.size(), 2);
      chk("tmo_zero_load", (loads.size() > 0) ? int'(loads[loads.size()-1]) : -1, 0);
      never_rdy = 1'b0;

      // Abort with cal_en during SETTLE of bit index 2.
      loads.delete();
      cal_target = N_FCAL_CNT'(700);
      cal_go = 1'b1;
      tick();
      cal_go = 1'b0;
      fin = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         if (loads.size() >= 3) begin fin = 1'b1; break; end
         tick();
      end
      chk("abort_reach_bit2", int'(fin), 1);
      tick(); tick(); tick(); tick();
      cal_en = 1'b0;
      tick();
      chk("abort_flags", int'({cal_busy, fcal_start, en_fcal, cal_done, cal_err}), 0);
      chk("abort_offset", int'(dco_ctl_offset), 12);
      tick(); tick(); tick();
      chk("abort_no_load", loads.size(), 3);
      cal_en = 1'b1;
      run_cal(700, 1'b0, fin);
      chk("abort_rerun", int'(fin & cal_done) * 100 + int'(dco_ctl_offset), 115);

      // Stale ack before cal_go.
      force_rdy = 1'b1;
      tick(); tick(); tick(); tick();
      loads.delete();
      cal_target = N_FCAL_CNT'(700);
      cal_go = 1'b1;
      tick();
      cal_go = 1'b0;
      fin = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (en_fcal) begin fin = 1'b1; break; end
         tick();
      end
      chk("stale_en_seen", int'(fin), 1);
      okflag = 1;
      for (int i = 0; i < 20; i++) begin
         if (fcal_start) okflag = 0;
         tick();
      end
      chk("stale_start_held_low", okflag, 1);
      force_rdy = 1'b0;
      fin = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         tick();
         if (cal_done || cal_err) begin fin = 1'b1; break; end
      end
      chk("stale_done", int'(fin & cal_done & ~cal_err), 1);
      chk("stale_offset", int'(dco_ctl_offset), 15);

      // Async reset while waiting for ack.
      cal_target = N_FCAL_CNT'(700);
      cal_go = 1'b1;
      tick();
      cal_go = 1'b0;
      fin = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (fcal_start) begin fin = 1'b1; break; end
         tick();
      end
      chk("rst_start_seen", int'(fin), 1);
      tick(); tick(); tick();
      rstn = 1'b0;
      #1;
      chk("rst_async_clear", int'({en_fcal, fcal_start, load_offset, dco_ctl_offset,
                                   cal_busy, cal_done, cal_err}), 0);
      tick(); tick();
      rstn = 1'b1;
      tick();
      run_cal(0, 1'b0, fin);
      chk("rst_recover", int'(fin & cal_done) * 100 + int'(dco_ctl_offset), 131);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
